// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits).
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the serialiser and expose fifo_count.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 348,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
`ifdef UART_TX_FIFO_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`endif
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY != 0);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state, state_n;
  logic [BAUD_W-1:0]     baud_cnt, baud_n;
  logic [3:0]            bit_cnt, bit_n;
  logic [DATA_BITS-1:0]  shift_reg, shift_n;
  logic                  par_bit, par_n;
  logic                  txd_n;
  logic                  bit_end;
  logic                  load;
  logic [DATA_BITS-1:0]  load_data;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop;

  assign tx_ready   = (count != FULL_COUNT) && !rst;
  assign push       = tx_valid && tx_ready;
  assign pop        = (state == ST_IDLE) && (count != '0);
  assign load       = pop;
  assign load_data  = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != ST_IDLE) || (count != '0);

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= tx_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign tx_ready  = (state == ST_IDLE) && !rst;
  assign load      = tx_valid && tx_ready;
  assign load_data = tx_data;
  assign busy      = (state != ST_IDLE);
`endif

  assign bit_end = (baud_cnt == LAST_BAUD);

  // txd_n is the level for the current state, so the line lags the state by one clock.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    par_n   = par_bit;
    txd_n   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_n = ST_START;
          baud_n  = '0;
          bit_n   = '0;
          shift_n = load_data;
          par_n   = (PARITY == 2) ? ^load_data : ~^load_data;
        end
      end
      ST_START: begin
        txd_n = 1'b0;
        if (bit_end) begin
          state_n = ST_DATA;
          baud_n  = '0;
          bit_n   = '0;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        txd_n = shift_reg[0];
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift_reg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_n = '0;
            if (HAS_PARITY) begin
              state_n = ST_PARITY;
            end else begin
              state_n = ST_STOP;
            end
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        txd_n = par_bit;
        if (bit_end) begin
          state_n = ST_STOP;
          baud_n  = '0;
          bit_n   = '0;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        txd_n = 1'b1;
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == LAST_STOP) begin
            state_n = ST_IDLE;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      txd       <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      par_bit   <= par_n;
      txd       <= txd_n;
    end
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised, fully synchronous UART transmitter; next generation of the team's 8-bit fixed-format TX.
- Serialises one word per valid/ready handshake onto txd.
- Configurable: data width, parity mode (none/odd/even), stop-bit count, baud divisor.
- Sits between the crypto core output stream and the board TX pin. Single clock domain; no edge-triggered logic on data or flag signals.

Parameters:
- CLKS_PER_BIT, 348, clk cycles per serial bit (≥2); 348 = 115200 baud at 40.09 MHz
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, TX FIFO entries, power of two ≥2; used only with UART_TX_FIFO_EN

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tx_data  input  DATA_BITS  word to send
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  block can accept a word this cycle
- txd  output  1  serial line, idle high
- busy  output  1  frame in progress (state ≠ IDLE)
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy (only with UART_TX_FIFO_EN)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: txd=1, busy=0, tx_ready=0 during reset (1 the cycle after release), fifo_count=0, state=IDLE, bit counter and baud counter 0.
- Handshake: word accepted on a rising clk edge where tx_valid & tx_ready. tx_data is latched into a shift register at acceptance and may change afterwards. tx_valid without tx_ready is ignored; nothing is queued.
- Without FIFO: tx_ready = (state == IDLE) & !rst.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE --accept--> START.
  - START --CLKS_PER_BIT cycles--> DATA.
  - DATA: sends DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles; then PARITY if PARITY ≠ 0, else STOP.
  - PARITY: held one bit time, then STOP.
  - STOP: held STOP_BITS × CLKS_PER_BIT cycles, then IDLE.
- Line levels: txd=0 in START; data bit in DATA; parity bit in PARITY; txd=1 in STOP and IDLE. txd is registered.
- Latency: txd falls on the first edge after the accept edge.
- Parity: even = XOR of all data bits; odd = inverted XOR.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; reset to 0 on every state entry. Bit periods are exact, no drift.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Inter-frame gap: exactly 1 idle-high cycle between back-to-back frames (the IDLE cycle).
- Reset mid-frame: frame abandoned; txd=1 on the next edge; FIFO flushed.
- Illegal parameters (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS ∉ {1,2}, CLKS_PER_BIT < 2): elaboration-time $error.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the serialiser.
  - tx_ready = !full.
  - The FSM pops the head in IDLE when the FIFO is non-empty.
  - Simultaneous push and pop is allowed: count unchanged.
  - Push while full is impossible, since tx_ready=0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is present.
  - busy = (state ≠ IDLE) | (fifo_count ≠ 0).
- Undefined: no FIFO, no fifo_count port; behaviour as in Behaviour.

Test Plan:
- 8N1, CLKS_PER_BIT=4: send 0x55 → txd holds 0,1,0,1,0,1,0,1,0,1 for 4 clks each (start, LSB-first data, stop); busy high for 40 clks; tx_ready returns 1 one cycle after STOP ends.
- 8E1, CLKS_PER_BIT=4: send 0x07 → parity bit 1; 8O1: send 0x07 → parity bit 0; frame 44 clks.
- 7-bit, 2 stop bits, CLKS_PER_BIT=3: send 0x7F, then 0x00 back-to-back with tx_valid held → second start bit begins exactly 1 clk after the first frame's 6 stop-bit clocks.
- Assert rst during DATA bit 3 of 0xA5 → txd=1 the next cycle, busy=0, tx_ready=1 the cycle after rst falls; the next word sends correctly.
- UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 words on consecutive cycles → after the first is popped into the serialiser, 4 remain queued; fifo_count reaches 4, tx_ready=0; the 5th is held until a pop; all 5 emitted in order.
- tx_data changed one cycle after accept → transmitted frame carries the originally accepted value.
